sram_like_axi_mux: RTL and testbench

//  N-master sram_like to AXI3 bridge: parametrised successor of the fixed two-port (inst/data) cpu_axi_interface.

---
 rtl/sram_like_axi_mux.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_sram_like_axi_mux.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_axi_mux.sv
// sram_like_axi_mux: N-master sram_like to AXI3 bridge.
// Reads and writes have independent round-robin arbiters and FSMs, so one read
// and one write can be in flight at once. The AXI ID carries the master index.
// A read to the word of the pending write is held off until that write ends.
// The AXI data ports are named axi_rdata / axi_wdata because rdata / wdata are
// the per-master sram_like data buses.
//
// Handshake rule on every AXI channel: a transfer happens on a rising clk edge
// where valid and ready are both high. Once raised, valid and its payload stay
// stable until that edge. Ready may be driven independently of valid.
module sram_like_axi_mux #(
  parameter int N_MST  = 2,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  // sram_like master side
  input  logic [N_MST-1:0]         req,
  input  logic [N_MST-1:0]         wr,
  input  logic [2*N_MST-1:0]       size,
  input  logic [ADDR_W*N_MST-1:0]  addr,
  input  logic [32*N_MST-1:0]      wdata,
  output logic [32*N_MST-1:0]      rdata,
  output logic [N_MST-1:0]         addr_ok,
  output logic [N_MST-1:0]         data_ok,
  // AXI read address
  output logic [ID_W-1:0]          arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  // AXI read data
  input  logic [ID_W-1:0]          rid,
  input  logic [31:0]              axi_rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  // AXI write address
  output logic [ID_W-1:0]          awid,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic [1:0]               awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  // AXI write data
  output logic [ID_W-1:0]          wid,
  output logic [31:0]              axi_wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  // AXI write response
  input  logic [ID_W-1:0]          bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  // FSM state visibility
  output logic [1:0]               dbg_r_state,
  output logic [1:0]               dbg_w_state
);

  localparam int PTR_W = (N_MST > 1) ? $clog2(N_MST) : 1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} w_state_t;

  r_state_t            r_state_q, r_state_d;
  w_state_t            w_state_q, w_state_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_mst_q, rd_mst_d, wr_mst_q, wr_mst_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [1:0]          rd_size_q, rd_size_d, wr_size_q, wr_size_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [3:0]          wr_strb_q, wr_strb_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [ADDR_W-1:0]   addr_a  [N_MST];
  logic [1:0]          size_a  [N_MST];
  logic [31:0]         wdata_a [N_MST];
  logic [N_MST-1:0]    rd_elig, wr_elig, rd_gnt, wr_gnt;
  logic                rd_found, wr_found;
  logic [PTR_W-1:0]    rd_idx, wr_idx, rd_cand, wr_cand;
  logic [PTR_W:0]      rd_sum, wr_sum;
  logic                r_busy, w_busy;
  logic                unused_resp;

  assign r_busy = (r_state_q != R_IDLE);
  assign w_busy = (w_state_q != W_IDLE);
  assign unused_resp = ^{rresp, rlast, bresp};

  // Unpack the flat per-master buses into arrays.
  always_comb begin
    for (int m = 0; m < N_MST; m++) begin
      addr_a[m]  = addr[m*ADDR_W +: ADDR_W];
      size_a[m]  = size[2*m +: 2];
      wdata_a[m] = wdata[32*m +: 32];
    end
  end

  // Read arbiter: first eligible reader at or after rd_ptr, skipping RAW hazards.
  always_comb begin
    rd_found = 1'b0;
    rd_idx   = '0;
    rd_gnt   = '0;
    rd_sum   = '0;
    rd_cand  = '0;
    for (int m = 0; m < N_MST; m++) begin
      rd_elig[m] = req[m] & ~wr[m]
                 & ~(w_busy & (wr_mst_q == PTR_W'(m)))
                 & ~(w_busy & (addr_a[m][ADDR_W-1:2] == wr_addr_q[ADDR_W-1:2]));
    end
    if (resetn && (r_state_q == R_IDLE)) begin
      for (int k = 0; k < N_MST; k++) begin
        rd_sum = {1'b0, rd_ptr_q} + (PTR_W+1)'(k);
        if (rd_sum >= (PTR_W+1)'(N_MST)) rd_sum = rd_sum - (PTR_W+1)'(N_MST);
        rd_cand = rd_sum[PTR_W-1:0];
        if (!rd_found && rd_elig[rd_cand]) begin
          rd_found = 1'b1;
          rd_idx   = rd_cand;
        end
      end
    end
    if (rd_found) rd_gnt[rd_idx] = 1'b1;
  end

  // Write arbiter: first writer at or after wr_ptr that has no read outstanding.
  always_comb begin
    wr_found = 1'b0;
    wr_idx   = '0;
    wr_gnt   = '0;
    wr_sum   = '0;
    wr_cand  = '0;
    for (int m = 0; m < N_MST; m++) begin
      wr_elig[m] = req[m] & wr[m] & ~(r_busy & (rd_mst_q == PTR_W'(m)));
    end
    if (resetn && (w_state_q == W_IDLE)) begin
      for (int k = 0; k < N_MST; k++) begin
        wr_sum = {1'b0, wr_ptr_q} + (PTR_W+1)'(k);
        if (wr_sum >= (PTR_W+1)'(N_MST)) wr_sum = wr_sum - (PTR_W+1)'(N_MST);
        wr_cand = wr_sum[PTR_W-1:0];
        if (!wr_found && wr_elig[wr_cand]) begin
          wr_found = 1'b1;
          wr_idx   = wr_cand;
        end
      end
    end
    if (wr_found) wr_gnt[wr_idx] = 1'b1;
  end

  // Read FSM next state: latch the granted request, then AR, then R.
  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    rd_size_d = rd_size_q;
    rd_mst_d  = rd_mst_q;
    rd_ptr_d  = rd_ptr_q;
    case (r_state_q)
      R_IDLE: if (rd_found) begin
        r_state_d = R_AR;
        rd_addr_d = addr_a[rd_idx];
        rd_size_d = size_a[rd_idx];
        rd_mst_d  = rd_idx;
        rd_ptr_d  = (rd_idx == PTR_W'(N_MST-1)) ? '0 : rd_idx + PTR_W'(1);
      end
      R_AR:    if (arready) r_state_d = R_DATA;
      R_DATA:  if (rvalid)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state: AW and W leave independently, response once both went.
  always_comb begin
    w_state_d = w_state_q;
    wr_addr_d = wr_addr_q;
    wr_size_d = wr_size_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    wr_mst_d  = wr_mst_q;
    wr_ptr_d  = wr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: if (wr_found) begin
        w_state_d = W_SEND;
        wr_addr_d = addr_a[wr_idx];
        wr_size_d = size_a[wr_idx];
        wr_data_d = wdata_a[wr_idx];
        wr_mst_d  = wr_idx;
        wr_ptr_d  = (wr_idx == PTR_W'(N_MST-1)) ? '0 : wr_idx + PTR_W'(1);
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        case (size_a[wr_idx])
          2'd0:    wr_strb_d = 4'b0001 << addr_a[wr_idx][1:0];
          2'd1:    wr_strb_d = 4'b0011 << addr_a[wr_idx][1:0];
          default: wr_strb_d = 4'b1111;
        endcase
      end
      W_SEND: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q  | wready;
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP:  if (bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight AXI transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_mst_q  <= '0;
      wr_mst_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_size_q <= '0;
      wr_size_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_mst_q  <= rd_mst_d;
      wr_mst_q  <= wr_mst_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_size_q <= rd_size_d;
      wr_size_q <= wr_size_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Master-side returns: data_ok decoded from the returned AXI ID.
  always_comb begin
    for (int m = 0; m < N_MST; m++) begin
      data_ok[m] = (rready & rvalid & (rid == ID_W'(m)))
                 | (bready & bvalid & (bid == ID_W'(m)));
    end
  end

  assign addr_ok = rd_gnt | wr_gnt;
  assign rdata   = {N_MST{axi_rdata}};

  assign arid    = ID_W'(rd_mst_q);
  assign araddr  = rd_addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, rd_size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (r_state_q == R_AR);
  assign rready  = (r_state_q == R_DATA);

  assign awid      = ID_W'(wr_mst_q);
  assign awaddr    = wr_addr_q;
  assign awlen     = 8'd0;
  assign awsize    = {1'b0, wr_size_q};
  assign awburst   = 2'b01;
  assign awlock    = 2'b00;
  assign awcache   = 4'd0;
  assign awprot    = 3'd0;
  assign awvalid   = (w_state_q == W_SEND) & ~aw_done_q;
  assign wid       = ID_W'(wr_mst_q);
  assign axi_wdata = wr_data_q;
  assign wstrb     = wr_strb_q;
  assign wlast     = 1'b1;
  assign wvalid    = (w_state_q == W_SEND) & ~w_done_q;
  assign bready    = (w_state_q == W_RESP);

  assign dbg_r_state = r_state_q;
  assign dbg_w_state = w_state_q;

endmodule

// File: tb/tb_sram_like_axi_mux.sv
// Randomized bench for sram_like_axi_mux: two sram_like masters, a randomly
// stalling AXI slave, and a transaction-level reference model of arbitration,
// hazard blocking and channel behaviour.
module tb_sram_like_axi_mux;
  localparam int N  = 2;
  localparam int IW = 4;
  localparam int AW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [N-1:0] req, wr, addr_ok, data_ok;
  logic [2*N-1:0] size;
  logic [AW*N-1:0] addr;
  logic [32*N-1:0] wdata, rdata;
  logic [IW-1:0] arid, rid, awid, wid, bid;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0] arcache, awcache, wstrb;
  logic [31:0] axi_rdata, axi_wdata;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [1:0] dbg_r_state, dbg_w_state;

  sram_like_axi_mux #(.N_MST(N), .ID_W(IW), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .axi_rdata(axi_rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .axi_wdata(axi_wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // master model: 0 idle, 1 requesting, 2 waiting for data_ok
  int          m_st    [N];
  logic        m_wr    [N];
  logic [1:0]  m_size  [N];
  logic [31:0] m_addr  [N];
  logic [31:0] m_wdata [N];

  // bridge model at transaction level
  bit rd_busy, rd_ar_pend, wr_busy, wr_aw_pend, wr_w_pend;
  int rd_m, wr_m, rd_ptr, wr_ptr;
  logic [29:0] wr_word;
  logic [31:0] exp_q[$];

  // slave model
  bit r_pend, b_pend;
  int r_dly, b_dly;
  logic [IW-1:0] r_id_s, b_id_s, aw_id_s;
  logic [31:0] r_addr_s;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // byte lanes covered by an access of 2**sz bytes at offset a[1:0]; words use all lanes
  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] s;
    int nb;
    int off;
    s = 4'b0000;
    nb = 1 << sz;
    off = int'(a[1:0]);
    for (int b = 0; b < 4; b++) s[b] = (sz >= 2'd2) || (b >= off && b < off + nb);
    return s;
  endfunction

  task automatic clear_model();
    for (int m = 0; m < N; m++) m_st[m] = 0;
    rd_busy = 0; rd_ar_pend = 0; wr_busy = 0; wr_aw_pend = 0; wr_w_pend = 0;
    rd_ptr = 0; wr_ptr = 0; rd_m = 0; wr_m = 0; wr_word = '0;
    r_pend = 0; b_pend = 0; r_dly = 0; b_dly = 0;
    exp_q.delete();
  endtask

  task automatic drive_masters(input bit allow_new);
    for (int m = 0; m < N; m++) begin
      if (m_st[m] == 0 && allow_new && $urandom_range(0, 2) == 0) begin
        m_wr[m]    = 1'($urandom_range(0, 1));
        m_size[m]  = 2'($urandom_range(0, 2));
        m_addr[m]  = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        m_wdata[m] = $urandom;
        m_st[m]    = 1;
      end
      req[m]           = (m_st[m] == 1);
      wr[m]            = m_wr[m];
      size[2*m +: 2]   = m_size[m];
      addr[AW*m +: AW] = m_addr[m];
      wdata[32*m +: 32] = m_wdata[m];
    end
  endtask

  task automatic drive_slave();
    arready = 1'($urandom_range(0, 1));
    awready = 1'($urandom_range(0, 1));
    wready  = 1'($urandom_range(0, 1));
    rvalid = 1'b0;
    if (r_pend) begin
      if (r_dly == 0) begin
        rvalid = 1'b1; rid = r_id_s; axi_rdata = mem_word(r_addr_s);
      end else r_dly--;
    end
    bvalid = 1'b0;
    if (b_pend) begin
      if (b_dly == 0) begin
        bvalid = 1'b1; bid = b_id_s; bresp = 2'($urandom_range(0, 3));
      end else b_dly--;
    end
  endtask

  // Compare one cycle of DUT outputs with the model, then advance the model.
  task automatic sample_and_check();
    logic [N-1:0] exp_aok, exp_dok;
    int g_rd, g_wr, m;
    bit was_send;
    g_rd = -1; g_wr = -1;
    if (!rd_busy)
      for (int k = 0; k < N; k++) begin
        m = (rd_ptr + k) % N;
        if (g_rd < 0 && m_st[m] == 1 && !m_wr[m] && !(wr_busy && m_addr[m][31:2] == wr_word)) g_rd = m;
      end
    if (!wr_busy)
      for (int k = 0; k < N; k++) begin
        m = (wr_ptr + k) % N;
        if (g_wr < 0 && m_st[m] == 1 && m_wr[m]) g_wr = m;
      end
    exp_aok = '0; exp_dok = '0;
    if (g_rd >= 0) exp_aok[g_rd] = 1'b1;
    if (g_wr >= 0) exp_aok[g_wr] = 1'b1;
    if (rvalid) exp_dok[rid] = 1'b1;
    if (bvalid) exp_dok[bid] = 1'b1;
    check("addr_ok", addr_ok, exp_aok);
    check("data_ok", data_ok, exp_dok);
    check("arvalid", arvalid, rd_ar_pend);
    check("rready", rready, rd_busy && !rd_ar_pend);
    check("awvalid", awvalid, wr_aw_pend);
    check("wvalid", wvalid, wr_w_pend);
    check("bready", bready, wr_busy && !wr_aw_pend && !wr_w_pend);

    if (rvalid) begin
      m = int'(rid);
      if (exp_q.size() == 0) check("rdata_unexpected", 1, 0);
      else check("rdata", rdata[32*m +: 32], exp_q.pop_front());
      m_st[m] = 0; rd_busy = 0; r_pend = 0; n_done++;
    end
    if (bvalid) begin
      m_st[int'(bid)] = 0; wr_busy = 0; b_pend = 0; n_done++;
    end
    if (rd_ar_pend && arready) begin
      check("arid", arid, rd_m);
      check("araddr", araddr, m_addr[rd_m]);
      check("arsize", arsize, {1'b0, m_size[rd_m]});
      rd_ar_pend = 0; r_pend = 1; r_dly = $urandom_range(0, 3);
      r_id_s = arid; r_addr_s = araddr;
    end
    was_send = wr_aw_pend || wr_w_pend;
    if (wr_aw_pend && awready) begin
      check("awid", awid, wr_m);
      check("awaddr", awaddr, m_addr[wr_m]);
      check("awsize", awsize, {1'b0, m_size[wr_m]});
      wr_aw_pend = 0; aw_id_s = awid;
    end
    if (wr_w_pend && wready) begin
      check("wdata", axi_wdata, m_wdata[wr_m]);
      check("wstrb", wstrb, exp_strb(m_size[wr_m], m_addr[wr_m]));
      check("wid", wid, wr_m);
      check("wlast", wlast, 1'b1);
      wr_w_pend = 0;
    end
    if (was_send && !wr_aw_pend && !wr_w_pend) begin
      b_pend = 1; b_dly = $urandom_range(0, 4); b_id_s = aw_id_s;
    end
    if (g_rd >= 0) begin
      rd_busy = 1; rd_ar_pend = 1; rd_m = g_rd; rd_ptr = (g_rd + 1) % N; m_st[g_rd] = 2;
      exp_q.push_back(mem_word(m_addr[g_rd]));
    end
    if (g_wr >= 0) begin
      wr_busy = 1; wr_aw_pend = 1; wr_w_pend = 1; wr_m = g_wr; wr_ptr = (g_wr + 1) % N;
      wr_word = m_addr[g_wr][31:2]; m_st[g_wr] = 2;
    end
  endtask

  task automatic drive_idle_inputs();
    req = '0; wr = '0; size = '0; addr = '0; wdata = '0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rid = '0; bid = '0; axi_rdata = '0; rresp = '0; bresp = '0; rlast = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    drive_idle_inputs();
    #1;
    check({tag, "_valids"}, {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    check({tag, "_addr_ok"}, addr_ok, '0);
    check({tag, "_data_ok"}, data_ok, '0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    bit rst_done;
    bit any_busy;
    rst_done = 0;
    for (int m = 0; m < N; m++) begin
      m_wr[m] = 0; m_size[m] = 0; m_addr[m] = 0; m_wdata[m] = 0;
    end
    clear_model();
    @(posedge clk);
    #1 do_reset("reset");
    check("consts_ar", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    check("consts_aw", {awlen, awburst, awlock, awcache, awprot}, {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (!rst_done && cyc >= 1200 && ((rd_busy && !rd_ar_pend) || cyc >= 2000)) begin
        do_reset("midrst");
        rst_done = 1;
      end
      drive_masters(cyc < 2700);
      drive_slave();
      @(negedge clk);
      sample_and_check();
    end

    any_busy = rd_busy || wr_busy;
    for (int m = 0; m < N; m++) if (m_st[m] != 0) any_busy = 1;
    check("drain_idle", any_busy, 1'b0);
    check("progress", n_done > 100, 1'b1);
    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
